fwd_bypass_unit: RTL

- Parametrised successor to the two-way forward muxes. Tracks in-flight destination registers in an internal tag pipeline and selects each operand from the youngest matching stage.
- Supports NUM_SRC operands and DEPTH bypass stages, and detects load-use hazards, raising stall and inserting bubbles.
- Sits between ID/EX operand read and the ALU input muxes. Replaces per-operand Forward A/B muxes and the separate hazard detector.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/fwd_operand_resolve.sv | 43 ++++
 rtl/fwd_bypass_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the forwarding/bypass unit.
// Tag entries record in-flight destination registers per bypass stage.
package pipe_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // Tag rd field is sized for the widest supported register address
  localparam int TAG_RD_W = 8;

  localparam int FWD_SEL_RF = 0;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic                v;
    logic [TAG_RD_W-1:0] rd;
    logic                late;
  } tag_t;

endpackage

// File: rtl/fwd_operand_resolve.sv
// Resolves one source operand against the in-flight tag pipeline.
// The youngest matching stage wins; a non-final result raises hazard.
module fwd_operand_resolve
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int DEPTH      = 2,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  tag_t [DEPTH-1:0]        tags,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  input  logic [DEPTH-1:0]        stage_data_valid,
  input  logic [REG_ADDR_W-1:0]   src_addr,
  input  logic [DATA_W-1:0]       rf_data,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       data,
  output logic                    hazard
);

  always_comb begin
    sel    = SEL_W'(FWD_SEL_RF);
    data   = rf_data;
    hazard = 1'b0;
    if (src_addr != REG_ADDR_W'(REG_ZERO)) begin
      // Oldest first, so a younger match overwrites it
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (tags[k].v &&
            tags[k].rd == TAG_RD_W'(src_addr)) begin
          sel = SEL_W'(k+1);
          if (stage_data_valid[k]) begin
            data   = stage_data[k*DATA_W +: DATA_W];
            hazard = 1'b0;
          end else begin
            data   = rf_data;
            hazard = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// Operand bypass network with internal destination tag pipeline,
// load-use stall detection and a saturating stall counter.
module fwd_bypass_unit
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_W-1:0]     issue_rd,
  input  logic                      issue_we,
  input  logic                      issue_late,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_rf_data,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  input  logic [DEPTH-1:0]          stage_data_valid,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [DEPTH-1:0]          tag_valid,
  output logic [CNT_W-1:0]          stall_cnt
);

  tag_t [DEPTH-1:0]   tags;
  tag_t               issue_tag;
  logic [NUM_SRC-1:0] hazard;

  always_comb begin
    issue_tag.v    = issue_valid & issue_we &
                     (issue_rd != REG_ADDR_W'(REG_ZERO));
    issue_tag.rd   = TAG_RD_W'(issue_rd);
    issue_tag.late = issue_valid & issue_we & issue_late;
  end

  // Flush beats stall beats issue when loading stage 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else if (flush) begin
      tags <= '0;
    end else begin
      tags[0] <= stall ? '0 : issue_tag;
      for (int k = 1; k < DEPTH; k++) begin
        tags[k] <= tags[k-1];
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_operand_resolve #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .DEPTH      (DEPTH),
      .SEL_W      (SEL_W)
    ) u_resolve (
      .tags             (tags),
      .stage_data       (stage_data),
      .stage_data_valid (stage_data_valid),
      .src_addr         (src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .rf_data          (src_rf_data[i*DATA_W +: DATA_W]),
      .sel              (fwd_sel[i*SEL_W +: SEL_W]),
      .data             (fwd_data[i*DATA_W +: DATA_W]),
      .hazard           (hazard[i])
    );
  end

  assign stall = (|hazard) & ~flush;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      tag_valid[k] = tags[k].v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // A load in stage 0 can never present a final result
  ap_late_not_valid: assert property (
    @(posedge clk) disable iff (!rst_n)
    (tags[0].v && tags[0].late) |-> !stage_data_valid[0]
  );

endmodule
